// File: rtl/serial_sub_nbit.sv
// rtl/serial_sub_nbit.sv - bit-serial N-bit subtractor (A - B - bin), LSB first, start/done handshake
`timescale 1ns/1ps
module serial_sub_nbit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [0:WIDTH-1] A,
    input  logic [0:WIDTH-1] B,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [0:WIDTH-1] Diff,
    output logic             bout,
    output logic             of
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [0:WIDTH-1] a_sh;
    logic [0:WIDTH-1] b_sh;
    logic             a_sign;
    logic             b_sign;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             a_bit;
    logic             b_bit;
    logic             d;
    logic             br_next;

    assign a_bit   = a_sh[WIDTH-1];
    assign b_bit   = b_sh[WIDTH-1];
    assign d       = a_bit ^ b_bit ^ br;
    assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);

    assign ready = (state != RUN);
    assign busy  = (state == RUN);

    // a_sh doubles as the partial result: difference bits enter at the MSB
    // end as minuend bits leave at the LSB end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            a_sign <= 1'b0;
            b_sign <= 1'b0;
            br     <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
            Diff   <= '0;
            bout   <= 1'b0;
            of     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        a_sign <= A[0];
                        b_sign <= B[0];
                        br     <= bin;
                        cnt    <= '0;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh <= {d, a_sh[0:WIDTH-2]};
                    b_sh <= {1'b0, b_sh[0:WIDTH-2]};
                    br   <= br_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        Diff  <= {d, a_sh[0:WIDTH-2]};
                        bout  <= br_next;
                        of    <= (a_sign != b_sign) && (d != a_sign);
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
